div_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one non_rest_div instance between NUM_REQ requesters. It accepts requests over per-port valid/ready handshakes, issues one start pulse per division, and waits for the divider's ready. It then returns quotient/remainder on a shared response bus tagged with a one-hot port select. Divide-by-zero is intercepted locally and never reaches the divider.

---
 rtl/div_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_div_rr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rr_arbiter.sv
// div_rr_arbiter: round-robin front end that shares one non_rest_div among
// NUM_REQ requesters. Divide-by-zero is answered locally without starting
// the divider.
module div_rr_arbiter #(
  parameter int WIDTH   = 256,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_dbz,
  output logic                     busy,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_ready,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand_idx;
  logic              sel_found;
  logic              accept;
  logic [WIDTH-1:0]  sel_dividend;
  logic [WIDTH-1:0]  sel_divisor;
  int unsigned       cand;

  // Pick the first valid port at or after the rr pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(rr_ptr) + i) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign sel_dividend = req_dividend[sel_idx*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor[sel_idx*WIDTH +: WIDTH];
  assign accept       = (state == IDLE) && sel_found;
  assign busy         = (state != IDLE);
  assign div_start    = (state == ISSUE);

  // Accept strobe; held low while reset is asserted so every output reads 0.
  always_comb begin
    req_ready = '0;
    if (accept && rst)
      req_ready[sel_idx] = 1'b1;
  end

  // Response valid is owned by the latched grant while in RESP.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP)
      rsp_valid[gnt_idx] = 1'b1;
  end

  // Sequencer state, grant index and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_idx <= sel_idx;
            rr_ptr  <= (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
            state   <= (sel_divisor == '0) ? RESP : ISSUE;
          end
        end
        ISSUE:   state <= GUARD;
        GUARD:   state <= WAIT;
        WAIT:    if (div_ready) state <= RESP;
        RESP:    if (rsp_ready[gnt_idx]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers to the divider and the shared response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
    end else begin
      if (accept) begin
        if (sel_divisor == '0) begin
          rsp_quotient  <= '1;
          rsp_remainder <= sel_dividend;
          rsp_dbz       <= 1'b1;
        end else begin
          div_dividend <= sel_dividend;
          div_divisor  <= sel_divisor;
        end
      end else if ((state == WAIT) && div_ready) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
        rsp_dbz       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_rr_arbiter.sv
// Scoreboard bench for div_rr_arbiter with a behavioural divider model.
module tb_div_rr_arbiter;

  localparam int W = 64;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_dbz;
  logic           busy;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_ready;
  logic [W-1:0]   div_quotient;
  logic [W-1:0]   div_remainder;

  div_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          port;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic        dbz;
    int unsigned acc_cyc;
  } exp_t;

  typedef struct {
    int          port;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
  } op_t;

  exp_t         sb[$];
  op_t          wq[$];
  int           glog[$];
  logic [N-1:0] pend = '0;
  logic [W-1:0] pdd [N];
  logic [W-1:0] pdv [N];
  int           ptr = 0;
  bit           free = 1'b1;
  bit           rand_mode = 1'b0;
  logic [N-1:0] rr_cfg = '1;

  // divider model controls
  int unsigned  next_lat = 3;
  bit           next_stale = 1'b0;
  int unsigned  rdy_cyc = 0;
  int unsigned  cnt = 0;
  logic [1:0]   phase = 2'd0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Divider: optionally keeps ready high one cycle after start with junk data,
  // then computes from the operands it sees when it finishes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ready     <= 1'b1;
      phase         <= 2'd0;
      cnt           <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      phase         <= 2'd1;
      cnt           <= next_lat;
      div_ready     <= next_stale;
      div_quotient  <= {$urandom, $urandom};
      div_remainder <= {$urandom, $urandom};
    end else if (phase == 2'd1) begin
      phase     <= 2'd2;
      div_ready <= 1'b0;
    end else if (phase == 2'd2) begin
      if (cnt == 0) begin
        phase         <= 2'd0;
        div_ready     <= 1'b1;
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
        rdy_cyc       <= cyc + 1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  function automatic int pick(int p0, logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[(p0 + i) % N]) return (p0 + i) % N;
    return -1;
  endfunction

  task automatic post(int p, logic [W-1:0] dd, logic [W-1:0] dv);
    op_t o;
    o.port = p; o.dd = dd; o.dv = dv;
    wq.push_back(o);
  endtask

  // Reference arbitration: free arbiter grants first valid port from ptr.
  task automatic check_arb();
    logic [N-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    if (free) g = pick(ptr, pend);
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      exp_t e;
      e.port    = g;
      e.dbz     = (pdv[g] == '0);
      e.q       = e.dbz ? '1 : pdd[g] / pdv[g];
      e.r       = e.dbz ? pdd[g] : pdd[g] % pdv[g];
      e.acc_cyc = cyc;
      sb.push_back(e);
      glog.push_back(g);
      ptr     = (g + 1) % N;
      free    = 1'b0;
      pend[g] = 1'b0;
    end else if (!free && ((rsp_valid & rsp_ready) != '0)) begin
      free = 1'b1;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (!pend[p]) begin
        for (int k = 0; k < wq.size(); k++) begin
          if (wq[k].port == p) begin
            pend[p] = 1'b1; pdd[p] = wq[k].dd; pdv[p] = wq[k].dv;
            wq.delete(k);
            break;
          end
        end
      end
    end
    if (rand_mode) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          pdd[p]  = {32'h0, $urandom};
          case ($urandom_range(0, 7))
            0:       pdv[p] = '0;
            1, 2:    pdv[p] = W'($urandom_range(1, 15));
            default: pdv[p] = {32'h0, $urandom >> $urandom_range(0, 31)};
          endcase
        end else if (pend[p] && $urandom_range(0, 19) == 0) begin
          pend[p] = 1'b0;
        end
      end
      rsp_ready  = N'($urandom);
      next_lat   = $urandom_range(0, 5);
      next_stale = 1'($urandom_range(0, 1));
    end else begin
      rsp_ready = rr_cfg;
    end
    req_valid = pend;
    for (int p = 0; p < N; p++) begin
      req_dividend[p*W +: W] = pdd[p];
      req_divisor[p*W +: W]  = pdv[p];
    end
  endtask

  // One cycle: check at the falling edge, drive just after the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    check_arb();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(int limit);
    int n = 0;
    while ((sb.size() != 0 || pend != '0 || wq.size() != 0 || !free) && n < limit) begin
      run_cycle();
      n++;
    end
    check("drain_done", 256'(n < limit), 256'(1));
  endtask

  task automatic check_reset_outputs();
    check("reset_ctrl", {req_ready, rsp_valid, rsp_dbz, busy, div_start}, '0);
    check("reset_rsp", {rsp_quotient, rsp_remainder}, '0);
    check("reset_div", {div_dividend, div_divisor}, '0);
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic hard_reset();
    #1 rst = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    wq.delete();
    pend      = '0;
    req_valid = '0;
    ptr       = 0;
    free      = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: compares every presented response with the scoreboard head.
  initial begin
    int  start_cnt = 0;
    bit  seen_first = 1'b0;
    bit  after_hs = 1'b0;
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        start_cnt  = 0;
        seen_first = 1'b0;
        after_hs   = 1'b0;
      end else begin
        if (after_hs) begin
          check("idle_after_accept", 256'(busy), '0);
          after_hs = 1'b0;
        end
        if (div_start) start_cnt++;
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 256'(rsp_valid), '0);
          end else begin
            e  = sb[0];
            oh = '0;
            oh[e.port] = 1'b1;
            check("rsp_data", {rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz},
                  {oh, e.q, e.r, e.dbz});
            if (!seen_first) begin
              seen_first = 1'b1;
              check("rsp_latency", 256'(cyc),
                    256'(e.dbz ? e.acc_cyc + 1 : rdy_cyc + 1));
            end
            if (rsp_ready[e.port]) begin
              check("div_start_count", 256'(start_cnt), 256'(e.dbz ? 0 : 1));
              start_cnt  = 0;
              seen_first = 1'b0;
              after_hs   = 1'b1;
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    #1 rst = 1'b1;

    // port 0: 100/10
    next_lat = 3; next_stale = 1'b0; rr_cfg = '1;
    post(0, 64'd100, 64'd10);
    drain(100);

    // port 2: 123/7 with its own rsp_ready low for 5 cycles, others high
    rr_cfg = 4'b1011;
    post(2, 64'd123, 64'd7);
    n = 0;
    while (!rsp_valid[2] && n < 100) begin run_cycle(); n++; end
    check("rsp_wait_p2", 256'(rsp_valid[2]), 256'(1));
    repeat (5) run_cycle();
    rr_cfg = 4'b0100;
    drain(50);
    rr_cfg = '1;

    // all ports valid continuously from a fresh pointer
    @(posedge clk); #1;
    hard_reset();
    glog.delete();
    post(0, 64'd5, 64'd3);
    post(1, 64'd105, 64'd4);
    post(2, 64'd205, 64'd5);
    post(3, 64'd305, 64'd6);
    post(0, 64'd5, 64'd3);
    drain(200);
    check("grant_count", 256'(glog.size()), 256'(5));
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check("grant_order", 256'(glog[i]), 256'(exp_order[i]));

    // port 1: divide by zero
    post(1, 64'd55, 64'd0);
    drain(50);

    // reset during WAIT of 1000/3, then pointer must restart at 0
    next_lat = 20;
    post(2, 64'd1000, 64'd3);
    n = 0;
    while (sb.size() == 0 && n < 50) begin run_cycle(); n++; end
    check("grant_before_reset", 256'(sb.size()), 256'(1));
    repeat (5) run_cycle();
    hard_reset();
    next_lat = 2;
    post(3, 64'd9, 64'd4);
    post(1, 64'd77, 64'd8);
    glog.delete();
    drain(100);
    check("post_reset_first_grant", 256'(glog.size() > 0 ? glog[0] : -1), 256'(1));

    // ready held high one cycle after start
    next_stale = 1'b1; next_lat = 4;
    post(0, 64'd999, 64'd7);
    drain(100);

    // randomized traffic with back-pressure and withdrawals
    rand_mode = 1'b1;
    repeat (600) run_cycle();
    rand_mode = 1'b0;
    rr_cfg = '1;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
